msft_dvip_bram_arbiter: RTL and testbench
=========================================

# msft_dvip_bram_arbiter

Two-requester arbiter and sequencer for the read/write port of the subsystem's 2-port FPGA block RAM model. It optionally zero-clears the RAM after reset, then shares the single read/write port between requester A (CPU data side) and requester B (DMA/loader side) using round-robin arbitration. It returns 1-cycle-latency read data to whichever requester owns the access. It sits between the bus adapters and the RAM; the RAM's read-only port is untouched.

## Interface
- RAM_WIDTH, 32, data width; also the width of the bitwise write strobe.
- RAM_DEPTH, 1024, number of words; address width is $clog2(RAM_DEPTH).
- INIT_CLEAR, 1, when 1, zero-fill the whole RAM after every reset before granting any requester.

- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- a_req, b_req  in  1  access request; held, with fields stable, until the matching gnt.
- a_addr, b_addr  in  $clog2(RAM_DEPTH)  word address.
- a_we, b_we  in  1  1 = write, 0 = read.
- a_wstrb, b_wstrb  in  RAM_WIDTH  bitwise write enable.
- a_wdata, b_wdata  in  RAM_WIDTH  write data.
- a_gnt, b_gnt  out  1  access accepted this cycle.
- a_rvalid, b_rvalid  out  1  read data valid.
- a_rdata, b_rdata  out  RAM_WIDTH  read data; meaningful only while the matching rvalid is 1.
- ram_cs, ram_we  out  1  RAM port controls.
- ram_addr  out  $clog2(RAM_DEPTH)  RAM address.
- ram_wstrb, ram_din  out  RAM_WIDTH  RAM write strobe and data.
- ram_dout  in  RAM_WIDTH  RAM read data, registered inside the RAM, 1 cycle after a read.
- init_done  out  1  high once the RAM is usable.

## Operation
- FSM states: CLEAR and RUN. Reset enters CLEAR if INIT_CLEAR=1, otherwise RUN.
- CLEAR:
  - Counter clr_addr runs from 0 to RAM_DEPTH-1, one word per cycle.
  - Each cycle drives ram_cs=1, ram_we=1, ram_wstrb=all ones, ram_din=0.
  - a_gnt and b_gnt are held at 0; requests are stalled, not dropped.
  - After the write at RAM_DEPTH-1, the FSM moves to RUN and the counter stops. No wrap-around.
  - Any RAM_DEPTH is supported, including non-power-of-2 values.
- RUN:
  - init_done=1.
  - If exactly one req is high, that requester is granted.
  - If both are high, grant the requester that does not hold the priority pointer's "last granted" mark.
  - The pointer updates on every grant. Its reset value is "B last", so A wins the first tie.
  - The granted requester's addr, we, wstrb and wdata drive the ram_* outputs, with ram_cs=1.
  - With no grant, ram_cs=0.
- Read response: a read granted in cycle N gives rvalid=1 for that requester in cycle N+1, with rdata=ram_dout. Writes produce no response.
- a_rdata and b_rdata are both wired to ram_dout; only rvalid is routed.
- Reset mid-operation:
  - All outputs go to reset values immediately.
  - An in-flight rvalid is lost.
  - CLEAR restarts at address 0.
- Reset values: a_gnt, b_gnt, a_rvalid, b_rvalid, ram_cs, ram_we and init_done are 0; ram_addr, ram_wstrb and ram_din are 0.

## Timing
- gnt is combinational from req, the FSM state and the registered pointer; same-cycle grant, 0 wait states.
- ram_* outputs are combinational from the grant mux (RUN) or from the counter (CLEAR).
- rvalid is registered; read latency is 1 cycle from gnt.
- Throughput is 1 access per cycle. Under contention each requester gets every other cycle; starvation is bounded at 1 cycle.
- Back-to-back reads from one requester give continuous rvalid.
- Write in cycle N, read of the same address in cycle N+1: the read returns the new data.
- Clear duration is exactly RAM_DEPTH cycles after reset release. init_done rises on the next edge after the last clear write.

## Structure
- Package msft_dvip_bram_arb_pkg holds:
  - the state enum {ARB_CLEAR, ARB_RUN};
  - the requester-id enum {REQ_A, REQ_B};
  - a request struct (addr, we, wstrb, wdata), parameterised by localparams matching the defaults.
- Sub-module msft_dvip_rr_arb2: a 2-way round-robin arbiter with req[1:0], an enable, gnt[1:0] and an internal last-grant flop. The top level instantiates one.
- The top level contains the FSM, the clear counter, the request mux and the rvalid routing flop.

## Test plan
- Clear: RAM_DEPTH=16, INIT_CLEAR=1, RAM preloaded with 0xA5A5A5A5. Release reset → 16 consecutive writes to addr 0..15 with data 0. init_done=1 at cycle 17; all words read back as 0.
- Stall during clear: a_req=1 (read at addr 3) asserted during CLEAR → no a_gnt until RUN. Then a_gnt fires in the first RUN cycle, and a_rvalid is high the next cycle with 0.
- Contention: a_req and b_req held for 4 cycles, A reading addr 1 and B reading addr 2 → grants A,B,A,B. rvalids follow 1 cycle later to the matching side.
- Write/read hazard: A writes 0xDEADBEEF with full strobe to addr 5, then reads addr 5 the next cycle → a_rdata=0xDEADBEEF. Partial strobe 0x000000FF with data 0 → readback 0xDEADBE00.
- Single requester: b_req held for 8 reads at addr 0..7 → b_gnt every cycle and 8 consecutive b_rvalid; A never sees rvalid.
- Reset mid-clear: rstn pulled low at clear cycle 5 and released → outputs 0 at once, and the clear restarts at addr 0 taking the full 16 cycles.

Source files
------------

// File: rtl/msft_dvip_bram_arb_pkg.sv
// ------------------------------------------------------------------------------
// msft_dvip_bram_arb_pkg: shared types for the BRAM arbiter slice (rev 1.0)
// ------------------------------------------------------------------------------
`default_nettype none

package msft_dvip_bram_arb_pkg;

  localparam int ARB_RAM_WIDTH = 32;
  localparam int ARB_RAM_DEPTH = 1024;
  localparam int ARB_ADDR_W    = $clog2(ARB_RAM_DEPTH);

  typedef enum logic {
    ARB_CLEAR = 1'b0,
    ARB_RUN   = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0]    addr;
    logic                     we;
    logic [ARB_RAM_WIDTH-1:0] wstrb;
    logic [ARB_RAM_WIDTH-1:0] wdata;
  } arb_req_t;

endpackage

`default_nettype wire

// File: rtl/msft_dvip_rr_arb2.sv
// ------------------------------------------------------------------------------
// msft_dvip_rr_arb2: 2-way round-robin arbiter with last-grant pointer (rev 1.0)
// ------------------------------------------------------------------------------
`default_nettype none

module msft_dvip_rr_arb2
  import msft_dvip_bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last;

  // On a tie the side that did not win last time goes next.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (last == REQ_B) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       last <= REQ_B;
    else if (gnt[0]) last <= REQ_A;
    else if (gnt[1]) last <= REQ_B;
  end

endmodule

`default_nettype wire

// File: rtl/msft_dvip_bram_arbiter.sv
// ------------------------------------------------------------------------------
// msft_dvip_bram_arbiter: post-reset RAM clear plus A/B sharing of the RW port (rev 1.0)
// ------------------------------------------------------------------------------
`default_nettype none

module msft_dvip_bram_arbiter
  import msft_dvip_bram_arb_pkg::*;
#(
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 1024,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         a_req,
  input  logic [$clog2(RAM_DEPTH)-1:0] a_addr,
  input  logic                         a_we,
  input  logic [RAM_WIDTH-1:0]         a_wstrb,
  input  logic [RAM_WIDTH-1:0]         a_wdata,
  input  logic                         b_req,
  input  logic [$clog2(RAM_DEPTH)-1:0] b_addr,
  input  logic                         b_we,
  input  logic [RAM_WIDTH-1:0]         b_wstrb,
  input  logic [RAM_WIDTH-1:0]         b_wdata,
  output logic                         a_gnt,
  output logic                         b_gnt,
  output logic                         a_rvalid,
  output logic                         b_rvalid,
  output logic [RAM_WIDTH-1:0]         a_rdata,
  output logic [RAM_WIDTH-1:0]         b_rdata,
  output logic                         ram_cs,
  output logic                         ram_we,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]         ram_wstrb,
  output logic [RAM_WIDTH-1:0]         ram_din,
  input  logic [RAM_WIDTH-1:0]         ram_dout,
  output logic                         init_done
);

  localparam int              AW          = $clog2(RAM_DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR   = AW'(RAM_DEPTH - 1);
  localparam arb_state_e      RESET_STATE = INIT_CLEAR ? ARB_CLEAR : ARB_RUN;

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic [AW-1:0] clr_addr;
  logic          arb_en;
  logic [1:0]    gnt;
  logic          rd_vld;
  req_id_e       rd_owner;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RESET_STATE;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_CLEAR && clr_addr != LAST_ADDR) clr_addr <= clr_addr + AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ARB_CLEAR && clr_addr == LAST_ADDR) state_nxt = ARB_RUN;
  end

  // Outputs are qualified by rstn so the port is idle while reset is held.
  assign arb_en    = rstn && (state == ARB_RUN);
  assign init_done = arb_en;

  msft_dvip_rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rstn (rstn),
    .en   (arb_en),
    .req  ({b_req, a_req}),
    .gnt  (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wstrb = '0;
    ram_din   = '0;
    if (rstn && state == ARB_CLEAR) begin
      ram_cs    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_wstrb = '1;
    end else if (gnt[0]) begin
      ram_cs    = 1'b1;
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wstrb = a_wstrb;
      ram_din   = a_wdata;
    end else if (gnt[1]) begin
      ram_cs    = 1'b1;
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wstrb = b_wstrb;
      ram_din   = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld   <= 1'b0;
      rd_owner <= REQ_A;
    end else begin
      rd_vld   <= (gnt[0] & ~a_we) | (gnt[1] & ~b_we);
      rd_owner <= gnt[1] ? REQ_B : REQ_A;
    end
  end

  assign a_rvalid = rd_vld && (rd_owner == REQ_A);
  assign b_rvalid = rd_vld && (rd_owner == REQ_B);
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule

`default_nettype wire

// File: tb/tb_msft_dvip_bram_arbiter.sv
// ------------------------------------------------------------------------------
// tb_msft_dvip_bram_arbiter: random + directed traffic against a cycle reference model (rev 1.0)
// ------------------------------------------------------------------------------
`default_nettype none

module tb_msft_dvip_bram_arbiter;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_wstrb, b_wstrb, a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0]   a_rdata, b_rdata;
  logic          ram_cs, ram_we, init_done;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wstrb, ram_din;
  logic [31:0]   ram_dout = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  msft_dvip_bram_arbiter #(.RAM_WIDTH(32), .RAM_DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wstrb(a_wstrb), .a_wdata(a_wdata),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wstrb(b_wstrb), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wstrb(ram_wstrb),
    .ram_din(ram_din), .ram_dout(ram_dout), .init_done(init_done)
  );

  // Behavioural RAM with registered read data, preloaded with a non-zero pattern.
  logic [31:0] ram_mem [DEPTH] = '{default: 32'hA5A5A5A5};
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_wstrb) | (ram_din & ram_wstrb);
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  // Reference model state
  logic [31:0] exp_mem [DEPTH];
  bit          m_clear;
  int          m_clr;
  bit          m_last_b;
  bit          m_av, m_bv;
  logic [31:0] m_rd;
  bit          last_ga, last_gb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Evaluate one cycle: inputs are already driven; check, advance model, move to next negedge.
  task automatic step();
    bit          ga, gb, we, nav, nbv;
    logic [AW-1:0] addr;
    logic [31:0] strb, din, nd;
    #1;
    ga = 0; gb = 0; nav = 0; nbv = 0; nd = '0;
    if (m_clear) begin
      check("clr_a_gnt", 32'(a_gnt), 32'd0);
      check("clr_b_gnt", 32'(b_gnt), 32'd0);
      check("clr_cs", 32'(ram_cs), 32'd1);
      check("clr_we", 32'(ram_we), 32'd1);
      check("clr_addr", 32'(ram_addr), 32'(m_clr));
      check("clr_strb", ram_wstrb, 32'hFFFFFFFF);
      check("clr_din", ram_din, 32'd0);
      check("clr_done", 32'(init_done), 32'd0);
      exp_mem[m_clr] = '0;
      if (m_clr == DEPTH - 1) m_clear = 0;
      else m_clr++;
    end else begin
      if (a_req && b_req) begin
        ga = m_last_b;
        gb = !m_last_b;
      end else begin
        ga = a_req;
        gb = b_req;
      end
      check("init_done", 32'(init_done), 32'd1);
      check("a_gnt", 32'(a_gnt), 32'(ga));
      check("b_gnt", 32'(b_gnt), 32'(gb));
      check("ram_cs", 32'(ram_cs), 32'(ga | gb));
      if (ga || gb) begin
        addr = ga ? a_addr : b_addr;
        we   = ga ? a_we : b_we;
        strb = ga ? a_wstrb : b_wstrb;
        din  = ga ? a_wdata : b_wdata;
        check("ram_addr", 32'(ram_addr), 32'(addr));
        check("ram_we", 32'(ram_we), 32'(we));
        check("ram_wstrb", ram_wstrb, strb);
        check("ram_din", ram_din, din);
        m_last_b = gb;
        if (we) begin
          exp_mem[addr] = (exp_mem[addr] & ~strb) | (din & strb);
        end else begin
          nd  = exp_mem[addr];
          nav = ga;
          nbv = gb;
        end
      end
    end
    check("a_rvalid", 32'(a_rvalid), 32'(m_av));
    check("b_rvalid", 32'(b_rvalid), 32'(m_bv));
    if (m_av) check("a_rdata", a_rdata, m_rd);
    if (m_bv) check("b_rdata", b_rdata, m_rd);
    m_av = nav;
    m_bv = nbv;
    m_rd = nd;
    last_ga = ga;
    last_gb = gb;
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    rstn  = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    #1;
    check("rst_cs", 32'(ram_cs), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_strb", ram_wstrb, 32'd0);
    check("rst_din", ram_din, 32'd0);
    check("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    repeat (hold) @(negedge clk);
    rstn     = 1'b1;
    m_clear  = 1;
    m_clr    = 0;
    m_last_b = 1;
    m_av     = 0;
    m_bv     = 0;
    last_ga  = 0;
    last_gb  = 0;
  endtask

  // A requester keeps its request and fields until granted, then may pick a new one.
  task automatic drive_random();
    if (!a_req || last_ga) begin
      a_req   = ($urandom_range(0, 99) < 60);
      a_addr  = AW'($urandom_range(0, DEPTH - 1));
      a_we    = 1'($urandom_range(0, 1));
      a_wstrb = $urandom;
      a_wdata = $urandom;
    end
    if (!b_req || last_gb) begin
      b_req   = ($urandom_range(0, 99) < 60);
      b_addr  = AW'($urandom_range(0, DEPTH - 1));
      b_we    = 1'($urandom_range(0, 1));
      b_wstrb = $urandom;
      b_wdata = $urandom;
    end
  endtask

  initial begin
    a_req = 0; a_addr = '0; a_we = 0; a_wstrb = '0; a_wdata = '0;
    b_req = 0; b_addr = '0; b_we = 0; b_wstrb = '0; b_wdata = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'hA5A5A5A5;

    // Clear with A stalled on a read of address 3
    do_reset(2);
    a_req = 1; a_we = 0; a_addr = 4'd3;
    repeat (DEPTH) step();
    step();
    check("stall_first_run_gnt", 32'(last_ga), 32'd1);
    a_req = 0;
    step();

    // B reads back every word back-to-back
    for (int i = 0; i < DEPTH; i++) begin
      b_req = 1; b_we = 0; b_addr = AW'(i);
      step();
    end
    b_req = 0;
    step();

    // Write followed immediately by read of the same word
    a_req = 1; a_we = 1; a_addr = 4'd5; a_wdata = 32'hDEADBEEF; a_wstrb = 32'hFFFFFFFF;
    step();
    a_we = 0;
    step();
    a_req = 0;
    check("hazard_full", a_rdata, 32'hDEADBEEF);
    step();
    a_req = 1; a_we = 1; a_wdata = 32'h0; a_wstrb = 32'h000000FF;
    step();
    a_we = 0;
    step();
    a_req = 0;
    check("hazard_partial", a_rdata, 32'hDEADBE00);
    step();

    // Random mixed traffic
    repeat (400) begin
      drive_random();
      step();
    end
    a_req = 0; b_req = 0;
    step();
    step();

    // Reset in the middle of a clear, then contention right after clear
    do_reset(2);
    repeat (5) step();
    do_reset(1);
    a_req = 1; a_we = 0; a_addr = 4'd1;
    b_req = 1; b_we = 0; b_addr = 4'd2;
    repeat (DEPTH) step();
    step();
    check("tie_first_a", 32'(last_ga), 32'd1);
    repeat (3) step();
    a_req = 0; b_req = 0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
